pdfd_tap_ctrl: RTL and testbench
================================

Name: pdfd_tap_ctrl

Overview:
- Sequencing and configuration controller for the lookahead PDFD decoder.
- Owns the decoder's 14 DFE feedback taps as a double-buffered bank: software writes a shadow bank, and the block commits it atomically to the active bank.
- Holds the decoder in reset while disabled.
- After every enable or commit, suppresses the decoder's valid output for the pipeline flush interval, so downstream logic never sees symbols decoded with mixed or stale taps.

Parameters:
- NUM_TAPS, 14, number of DFE feedback taps driven to the decoder.
- TAP_W, 8, signed tap width.
- IDX_W, 4, width of the tap index (must satisfy 2^IDX_W >= NUM_TAPS).
- FLUSH_CYCLES, 16, decoder pipeline latency in cycles; output valid is masked for this many cycles; must be >= 1.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_enable  in  1  level; 1 = run the decoder, 0 = idle it.
- io_commit  in  1  single-cycle pulse requesting shadow->active copy; ignored unless in RUN.
- io_cfgValid  in  1  tap write request.
- io_cfgReady  out  1  write accepted when io_cfgValid && io_cfgReady.
- io_cfgIdx  in  IDX_W  shadow tap index.
- io_cfgTap  in  TAP_W  signed tap value.
- io_decValid  in  1  rxValid from the decoder.
- io_taps  out  NUM_TAPS*TAP_W  active taps, flattened; tap k occupies bits [k*TAP_W +: TAP_W].
- io_decReset  out  1  synchronous reset to the decoder.
- io_outValid  out  1  gated valid for downstream.
- io_state  out  2  current state: 0 IDLE, 1 COMMIT, 2 FLUSH, 3 RUN.
- io_cfgErr  out  1  sticky flag: an out-of-range index write was attempted.

Behaviour:
- Reset (async): state=IDLE; shadow and active banks all 0; flush counter 0; io_cfgErr=0; io_decReset=1; io_outValid=0; io_cfgReady=0 while reset is held, 1 in IDLE after reset.
- All outputs are registered or decoded from state; none depend combinationally on io_commit or io_cfgValid.
- Shadow writes:
  - A write is accepted when io_cfgValid && io_cfgReady.
  - If io_cfgIdx < NUM_TAPS, shadow[idx] <= io_cfgTap.
  - Otherwise the write is dropped and io_cfgErr is set; io_cfgErr clears only on reset.
  - io_cfgReady=0 in COMMIT and 1 in every other state.
- IDLE:
  - io_decReset=1, io_outValid=0.
  - io_enable=1 -> COMMIT.
- COMMIT (exactly 1 cycle):
  - active <= shadow for all taps in the same edge.
  - io_decReset=0.
  - Load flush counter = FLUSH_CYCLES-1 -> FLUSH.
- FLUSH:
  - io_outValid=0, io_decReset=0.
  - Counter decrements each cycle; when counter==0 -> RUN.
  - FLUSH therefore lasts exactly FLUSH_CYCLES cycles.
- RUN:
  - io_outValid = io_decValid (combinational AND with state==RUN).
  - io_commit=1 -> COMMIT.
- io_enable=0 in any state -> IDLE on the next edge. This has priority over io_commit and over flush completion.
- Active taps persist into IDLE and are overwritten only by COMMIT.
- io_commit outside RUN is ignored; it is not queued.
- A write accepted in the same cycle as io_commit in RUN lands in shadow on that edge and is included in the following COMMIT copy.
- Latency:
  - io_enable rise -> first possible io_outValid = 1 + FLUSH_CYCLES + 1 edges (IDLE->COMMIT, FLUSH_CYCLES, then RUN).
  - io_commit -> new taps visible on io_taps 1 edge after entering COMMIT.

Optional Feature:
- Macro: PDFD_TAP_READBACK_EN.
- Defined:
  - Adds inputs io_rdEn (1) and io_rdIdx (IDX_W), and outputs io_rdData (TAP_W) and io_rdValid (1).
  - io_rdEn samples io_rdIdx; one cycle later io_rdValid=1 and io_rdData=shadow[idx], reflecting any write accepted in the same cycle as the read.
  - An out-of-range index returns 0 with io_rdValid=1.
  - Reset values are 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles -> io_state=0, io_decReset=1, io_taps all 0, io_outValid=0, io_cfgErr=0.
- Write taps 0..13 = 1..14 in IDLE, raise io_enable, hold io_decValid=1 -> io_taps updates at the COMMIT edge; io_outValid=0 for exactly 16 cycles, then 1.
- In RUN, write tap 3 = -5 and pulse io_commit in the same cycle -> io_taps[3]=-5 after COMMIT; io_cfgReady=0 for 1 cycle; io_outValid low 17 cycles.
- Write with io_cfgIdx=14 and 15 -> shadow unchanged, io_cfgErr=1 and stays 1 through later commits.
- Drop io_enable mid-FLUSH (counter=7) with io_commit=1 -> next state IDLE, io_decReset=1, active taps retained.
- With PDFD_TAP_READBACK_EN: write tap 5=42, read idx 5 the same cycle -> io_rdValid=1 and io_rdData=42 one cycle later; read idx 15 -> io_rdData=0.

Source files
------------

// File: rtl/pdfd_tap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pdfd_tap_ctrl_if
// Description : Control/configuration bundle between software-side logic and
//               the PDFD tap controller. The read-back signals exist only when
//               PDFD_TAP_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdfd_tap_ctrl_if #(
    parameter int NUM_TAPS = 14,
    parameter int TAP_W    = 8,
    parameter int IDX_W    = 4
);
    logic                      io_enable;
    logic                      io_commit;
    logic                      io_cfgValid;
    logic                      io_cfgReady;
    logic [IDX_W-1:0]          io_cfgIdx;
    logic signed [TAP_W-1:0]   io_cfgTap;
    logic                      io_decValid;
    logic [NUM_TAPS*TAP_W-1:0] io_taps;
    logic                      io_decReset;
    logic                      io_outValid;
    logic [1:0]                io_state;
    logic                      io_cfgErr;
`ifdef PDFD_TAP_READBACK_EN
    logic                      io_rdEn;
    logic [IDX_W-1:0]          io_rdIdx;
    logic [TAP_W-1:0]          io_rdData;
    logic                      io_rdValid;

    modport master (
        output io_enable, io_commit, io_cfgValid, io_cfgIdx, io_cfgTap,
               io_decValid, io_rdEn, io_rdIdx,
        input  io_cfgReady, io_taps, io_decReset, io_outValid, io_state,
               io_cfgErr, io_rdData, io_rdValid
    );

    modport slave (
        input  io_enable, io_commit, io_cfgValid, io_cfgIdx, io_cfgTap,
               io_decValid, io_rdEn, io_rdIdx,
        output io_cfgReady, io_taps, io_decReset, io_outValid, io_state,
               io_cfgErr, io_rdData, io_rdValid
    );
`else
    modport master (
        output io_enable, io_commit, io_cfgValid, io_cfgIdx, io_cfgTap,
               io_decValid,
        input  io_cfgReady, io_taps, io_decReset, io_outValid, io_state,
               io_cfgErr
    );

    modport slave (
        input  io_enable, io_commit, io_cfgValid, io_cfgIdx, io_cfgTap,
               io_decValid,
        output io_cfgReady, io_taps, io_decReset, io_outValid, io_state,
               io_cfgErr
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pdfd_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdfd_tap_ctrl
// Description : Sequencing/configuration controller for the lookahead PDFD
//               decoder. Double-buffered DFE tap bank (shadow -> active on
//               COMMIT), decoder reset while idle, and valid masking for the
//               pipeline flush interval after every enable or commit.
//               Optional shadow read-back port: define PDFD_TAP_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pdfd_tap_ctrl #(
    parameter int NUM_TAPS     = 14,
    parameter int TAP_W        = 8,
    parameter int IDX_W        = 4,   // 2**IDX_W must cover NUM_TAPS
    parameter int FLUSH_CYCLES = 16   // must be >= 1
) (
    input  logic              clock,
    input  logic              reset,
    pdfd_tap_ctrl_if.slave    bus
);

    localparam int             c_cnt_w      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [1:0]     c_st_idle    = 2'd0;
    localparam logic [1:0]     c_st_commit  = 2'd1;
    localparam logic [1:0]     c_st_flush   = 2'd2;
    localparam logic [1:0]     c_st_run     = 2'd3;
    localparam logic [c_cnt_w-1:0] c_flush_load = c_cnt_w'(FLUSH_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [IDX_W:0] c_num_taps   = (IDX_W + 1)'(NUM_TAPS);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [c_cnt_w-1:0]        r_flush_cnt;
    logic [NUM_TAPS*TAP_W-1:0] r_shadow;
    logic [NUM_TAPS*TAP_W-1:0] r_active;
    logic                      r_cfg_ready;
    logic                      r_cfg_err;
    logic                      w_wr_acc;
    logic                      w_idx_ok;

    assign w_wr_acc = bus.io_cfgValid && r_cfg_ready;
    assign w_idx_ok = ({1'b0, bus.io_cfgIdx} < c_num_taps);

    // Next-state decode; dropping enable wins over everything else.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.io_enable) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   w_state_nxt = c_st_commit;
                c_st_commit: w_state_nxt = c_st_flush;
                c_st_flush:  if (r_flush_cnt == '0) w_state_nxt = c_st_run;
                c_st_run:    if (bus.io_commit) w_state_nxt = c_st_commit;
                default:     w_state_nxt = c_st_idle;
            endcase
        end
    end

    // State register; write-ready is registered from the next state so it
    // never depends combinationally on the handshake inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cfg_ready <= (w_state_nxt != c_st_commit);
        end
    end

    // Flush counter: loaded in COMMIT, counts down to zero in FLUSH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flush_cnt <= '0;
        end else if (r_state == c_st_commit) begin
            r_flush_cnt <= c_flush_load;
        end else if ((r_state == c_st_flush) && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - c_cnt_one;
        end
    end

    // Shadow bank writes; out-of-range indices are dropped and flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (w_wr_acc && (bus.io_cfgIdx == IDX_W'(k))) begin
                    r_shadow[k*TAP_W +: TAP_W] <= bus.io_cfgTap;
                end
            end
            if (w_wr_acc && !w_idx_ok) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // Active bank takes the whole shadow bank on the edge leaving COMMIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active <= '0;
        end else if (r_state == c_st_commit) begin
            r_active <= r_shadow;
        end
    end

    assign bus.io_taps     = r_active;
    assign bus.io_decReset = (r_state == c_st_idle);
    assign bus.io_outValid = bus.io_decValid && (r_state == c_st_run);
    assign bus.io_state    = r_state;
    assign bus.io_cfgReady = r_cfg_ready;
    assign bus.io_cfgErr   = r_cfg_err;

`ifdef PDFD_TAP_READBACK_EN
    logic [TAP_W-1:0] w_rd_data;
    logic [TAP_W-1:0] r_rd_data;
    logic             r_rd_valid;

    // Read mux forwards a same-cycle accepted write so the read sees it.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (bus.io_rdIdx == IDX_W'(k)) begin
                if (w_wr_acc && (bus.io_cfgIdx == IDX_W'(k))) begin
                    w_rd_data = bus.io_cfgTap;
                end else begin
                    w_rd_data = r_shadow[k*TAP_W +: TAP_W];
                end
            end
        end
    end

    // Read response registered one cycle after the request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.io_rdEn;
            if (bus.io_rdEn) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

    assign bus.io_rdData  = r_rd_data;
    assign bus.io_rdValid = r_rd_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pdfd_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdfd_tap_ctrl
// Description : Self-checking bench for pdfd_tap_ctrl: directed scenarios
//               plus randomized traffic compared to a cycle-level reference
//               model of the tap banks, sequencing and masking rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdfd_tap_ctrl;

    localparam int NT = 14;
    localparam int TW = 8;
    localparam int IW = 4;
    localparam int FL = 16;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    pdfd_tap_ctrl_if #(.NUM_TAPS(NT), .TAP_W(TW), .IDX_W(IW)) bus ();

    pdfd_tap_ctrl #(
        .NUM_TAPS(NT), .TAP_W(TW), .IDX_W(IW), .FLUSH_CYCLES(FL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [TW-1:0] m_shadow [NT];
    logic [TW-1:0] m_active [NT];
    bit            m_err;
    bit            m_ready;
    bit            m_idle;       // decoder held in reset
    bit            m_in_commit;  // one-cycle copy phase
    int            m_left;       // flush cycles still to go (0 = running)
    bit            m_rd_valid;
    logic [TW-1:0] m_rd_data;

    function automatic logic [NT*TW-1:0] m_taps();
        logic [NT*TW-1:0] v;
        for (int k = 0; k < NT; k++) v[k*TW +: TW] = m_active[k];
        return v;
    endfunction

    function automatic logic [1:0] m_state();
        if (m_idle) return 2'd0;
        if (m_in_commit) return 2'd1;
        if (m_left > 0) return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_err = 0; m_ready = 0; m_idle = 1; m_in_commit = 0; m_left = 0;
        m_rd_valid = 0; m_rd_data = '0;
    endtask

    task automatic model_edge();
        int idx;
        idx = int'(bus.io_cfgIdx);
        if (m_in_commit) m_active = m_shadow;
        if (bus.io_cfgValid && m_ready) begin
            if (idx < NT) m_shadow[idx] = bus.io_cfgTap;
            else          m_err = 1;
        end
`ifdef PDFD_TAP_READBACK_EN
        m_rd_valid = bus.io_rdEn;
        if (bus.io_rdEn)
            m_rd_data = (int'(bus.io_rdIdx) < NT) ? m_shadow[int'(bus.io_rdIdx)] : '0;
`endif
        if (!bus.io_enable) begin
            m_idle = 1; m_in_commit = 0; m_left = 0;
        end else if (m_idle) begin
            m_idle = 0; m_in_commit = 1;
        end else if (m_in_commit) begin
            m_in_commit = 0; m_left = FL;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (bus.io_commit) begin
            m_in_commit = 1;
        end
        m_ready = !m_in_commit;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.io_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.io_state); end
        checks++; if (bus.io_decReset !== 1'b1) begin errors++; $display("FAIL reset_decReset: got %b expected 1", bus.io_decReset); end
        checks++; if (bus.io_taps !== '0) begin errors++; $display("FAIL reset_taps: got %h expected 0", bus.io_taps); end
        checks++; if (bus.io_outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b expected 0", bus.io_outValid); end
        checks++; if (bus.io_cfgErr !== 1'b0) begin errors++; $display("FAIL reset_cfgErr: got %b expected 0", bus.io_cfgErr); end
        checks++; if (bus.io_cfgReady !== 1'b0) begin errors++; $display("FAIL reset_cfgReady: got %b expected 0", bus.io_cfgReady); end
        reset = 0;
        model_reset();
        tick();
        checks++; if (bus.io_cfgReady !== 1'b1) begin errors++; $display("FAIL idle_cfgReady: got %b expected 1", bus.io_cfgReady); end
    endtask

    task automatic test_first_enable();
        logic [NT*TW-1:0] exp;
        int n;
        for (int k = 0; k < NT; k++) begin
            bus.io_cfgValid = 1; bus.io_cfgIdx = IW'(k); bus.io_cfgTap = TW'(k + 1);
            exp[k*TW +: TW] = TW'(k + 1);
            tick();
        end
        bus.io_cfgValid = 0;
        checks++; if (bus.io_taps !== '0) begin errors++; $display("FAIL en_taps_pre: got %h expected 0", bus.io_taps); end
        bus.io_enable = 1; bus.io_decValid = 1;
        tick();
        checks++; if (bus.io_state !== 2'd1) begin errors++; $display("FAIL en_commit_state: got %0d expected 1", bus.io_state); end
        checks++; if (bus.io_cfgReady !== 1'b0) begin errors++; $display("FAIL en_commit_ready: got %b expected 0", bus.io_cfgReady); end
        tick();
        checks++; if (bus.io_taps !== exp) begin errors++; $display("FAIL en_taps: got %h expected %h", bus.io_taps, exp); end
        n = 0;
        while (bus.io_outValid === 1'b0 && n < 40) begin n++; tick(); end
        checks++; if (n !== FL) begin errors++; $display("FAIL en_flush_len: got %0d expected %0d", n, FL); end
        checks++; if (bus.io_state !== 2'd3) begin errors++; $display("FAIL en_run_state: got %0d expected 3", bus.io_state); end
    endtask

    task automatic test_commit_in_run();
        int n;
        int rdy_low;
        bus.io_cfgValid = 1; bus.io_cfgIdx = 4'd3; bus.io_cfgTap = -8'sd5; bus.io_commit = 1;
        tick();
        bus.io_cfgValid = 0; bus.io_commit = 0;
        checks++; if (bus.io_state !== 2'd1) begin errors++; $display("FAIL cr_state: got %0d expected 1", bus.io_state); end
        checks++; if (bus.io_taps[3*TW +: TW] !== 8'd4) begin errors++; $display("FAIL cr_old_tap3: got %h expected 04", bus.io_taps[3*TW +: TW]); end
        n = 0; rdy_low = 0;
        while (bus.io_outValid === 1'b0 && n < 40) begin
            if (bus.io_cfgReady !== 1'b1) rdy_low++;
            n++; tick();
        end
        checks++; if (n !== FL + 1) begin errors++; $display("FAIL cr_mask_len: got %0d expected %0d", n, FL + 1); end
        checks++; if (rdy_low !== 1) begin errors++; $display("FAIL cr_ready_low: got %0d expected 1", rdy_low); end
        checks++; if (bus.io_taps[3*TW +: TW] !== 8'hFB) begin errors++; $display("FAIL cr_new_tap3: got %h expected fb", bus.io_taps[3*TW +: TW]); end
    endtask

    task automatic test_bad_index();
        int n;
        bus.io_cfgValid = 1; bus.io_cfgIdx = 4'd14; bus.io_cfgTap = 8'h55;
        tick();
        bus.io_cfgIdx = 4'd15; bus.io_cfgTap = 8'h66;
        tick();
        bus.io_cfgValid = 0;
        checks++; if (bus.io_cfgErr !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b expected 1", bus.io_cfgErr); end
        bus.io_commit = 1;
        tick();
        bus.io_commit = 0;
        n = 0;
        while (bus.io_state !== 2'd3 && n < 50) begin n++; tick(); end
        checks++; if (bus.io_state !== 2'd3) begin errors++; $display("FAIL bad_reach_run: got %0d expected 3", bus.io_state); end
        checks++; if (bus.io_taps !== m_taps()) begin errors++; $display("FAIL bad_taps: got %h expected %h", bus.io_taps, m_taps()); end
        checks++; if (bus.io_cfgErr !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b expected 1", bus.io_cfgErr); end
    endtask

    task automatic test_disable_mid_flush();
        logic [NT*TW-1:0] exp;
        bus.io_commit = 1;
        tick();
        bus.io_commit = 0;
        tick();
        repeat (8) tick();
        checks++; if (bus.io_state !== 2'd2) begin errors++; $display("FAIL dis_in_flush: got %0d expected 2", bus.io_state); end
        exp = m_taps();
        bus.io_enable = 0; bus.io_commit = 1;
        tick();
        bus.io_commit = 0;
        checks++; if (bus.io_state !== 2'd0) begin errors++; $display("FAIL dis_state: got %0d expected 0", bus.io_state); end
        checks++; if (bus.io_decReset !== 1'b1) begin errors++; $display("FAIL dis_decReset: got %b expected 1", bus.io_decReset); end
        checks++; if (bus.io_taps !== exp) begin errors++; $display("FAIL dis_taps: got %h expected %h", bus.io_taps, exp); end
        tick();
        checks++; if (bus.io_state !== 2'd0) begin errors++; $display("FAIL dis_stay_idle: got %0d expected 0", bus.io_state); end
    endtask

`ifdef PDFD_TAP_READBACK_EN
    task automatic test_readback();
        bus.io_cfgValid = 1; bus.io_cfgIdx = 4'd5; bus.io_cfgTap = 8'd42;
        bus.io_rdEn = 1; bus.io_rdIdx = 4'd5;
        tick();
        bus.io_cfgValid = 0; bus.io_rdIdx = 4'd15;
        checks++; if (bus.io_rdValid !== 1'b1) begin errors++; $display("FAIL rb_valid: got %b expected 1", bus.io_rdValid); end
        checks++; if (bus.io_rdData !== 8'd42) begin errors++; $display("FAIL rb_data: got %0d expected 42", bus.io_rdData); end
        tick();
        bus.io_rdEn = 0;
        checks++; if (bus.io_rdData !== 8'd0) begin errors++; $display("FAIL rb_oor: got %0d expected 0", bus.io_rdData); end
        tick();
        checks++; if (bus.io_rdValid !== 1'b0) begin errors++; $display("FAIL rb_valid_drop: got %b expected 0", bus.io_rdValid); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.io_enable   = ($urandom_range(0, 39) != 0);
            bus.io_commit   = ($urandom_range(0, 7) == 0);
            bus.io_cfgValid = $urandom_range(0, 1);
            bus.io_cfgIdx   = IW'($urandom_range(0, 15));
            bus.io_cfgTap   = TW'($urandom);
            bus.io_decValid = $urandom_range(0, 1);
`ifdef PDFD_TAP_READBACK_EN
            bus.io_rdEn     = $urandom_range(0, 1);
            bus.io_rdIdx    = IW'($urandom_range(0, 15));
`endif
            tick();
            checks++; if (bus.io_state !== m_state()) begin errors++; $display("FAIL rnd_state @%0d: got %0d expected %0d", i, bus.io_state, m_state()); end
            checks++; if (bus.io_taps !== m_taps()) begin errors++; $display("FAIL rnd_taps @%0d: got %h expected %h", i, bus.io_taps, m_taps()); end
            checks++; if (bus.io_decReset !== m_idle) begin errors++; $display("FAIL rnd_decReset @%0d: got %b expected %b", i, bus.io_decReset, m_idle); end
            checks++; if (bus.io_outValid !== (bus.io_decValid && m_state() == 2'd3)) begin errors++; $display("FAIL rnd_outValid @%0d: got %b", i, bus.io_outValid); end
            checks++; if (bus.io_cfgReady !== m_ready) begin errors++; $display("FAIL rnd_cfgReady @%0d: got %b expected %b", i, bus.io_cfgReady, m_ready); end
            checks++; if (bus.io_cfgErr !== m_err) begin errors++; $display("FAIL rnd_cfgErr @%0d: got %b expected %b", i, bus.io_cfgErr, m_err); end
`ifdef PDFD_TAP_READBACK_EN
            checks++; if (bus.io_rdValid !== m_rd_valid) begin errors++; $display("FAIL rnd_rdValid @%0d: got %b expected %b", i, bus.io_rdValid, m_rd_valid); end
            if (m_rd_valid) begin
                checks++; if (bus.io_rdData !== m_rd_data) begin errors++; $display("FAIL rnd_rdData @%0d: got %h expected %h", i, bus.io_rdData, m_rd_data); end
            end
`endif
        end
    endtask

    initial begin
        clock = 0; reset = 1; errors = 0; checks = 0;
        bus.io_enable = 0; bus.io_commit = 0; bus.io_cfgValid = 0;
        bus.io_cfgIdx = '0; bus.io_cfgTap = '0; bus.io_decValid = 0;
`ifdef PDFD_TAP_READBACK_EN
        bus.io_rdEn = 0; bus.io_rdIdx = '0;
`endif
        model_reset();
        test_reset();
        test_first_enable();
        test_commit_in_run();
        test_bad_index();
        test_disable_mid_flush();
`ifdef PDFD_TAP_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
